// File: rtl/fp2int_cvt_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : fp2int_cvt_sched                                           |
// | Description : Shares one combinational bf16->int32 converter between     |
// |               NUM_REQ requesters. Round-robin arbitration, operand       |
// |               classification, and a two-stage pipeline (issue register   |
// |               feeding the converter, then a result register).            |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
// | Ports                                                                    |
// |   clk_i, rst_i        clock (rising edge), synchronous active-high reset |
// |   req_valid_i/ready_o per-requester request handshake                    |
// |   req_op_i, req_tag_i packed bf16 operands and opaque tags               |
// |   rsp_valid_o/ready_i per-requester response handshake (one-hot valid)   |
// |   rsp_result_o/flag_o/tag_o  shared response bus, zero when empty        |
// |   cvt_op_o/class_o    operand and class driven to the converter          |
// |   cvt_result_i/flag_i converter outputs (combinational from cvt_*_o)     |
// |   flag_sticky_o, flag_clr_i  accumulated delivered flags and its clear   |
// |   cvt_count_o         delivered-response counter (wraps)                 |
// |   busy_o              either pipeline stage occupied                     |
// +--------------------------------------------------------------------------+

package fp2int_cvt_pkg;
  typedef enum logic [2:0] {
    Sub_Norm = 3'd0,
    Norm     = 3'd1,
    Inf      = 3'd2,
    Neg_Inf  = 3'd3,
    NaN      = 3'd4
  } Classif_e;
endpackage

module fp2int_cvt_sched
  import fp2int_cvt_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned TAG_W   = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NUM_REQ-1:0]       req_valid_i,
  output logic [NUM_REQ-1:0]       req_ready_o,
  input  logic [NUM_REQ*16-1:0]    req_op_i,
  input  logic [NUM_REQ*TAG_W-1:0] req_tag_i,
  output logic [NUM_REQ-1:0]       rsp_valid_o,
  input  logic [NUM_REQ-1:0]       rsp_ready_i,
  output logic [31:0]              rsp_result_o,
  output logic [2:0]               rsp_flag_o,
  output logic [TAG_W-1:0]         rsp_tag_o,
  output logic [15:0]              cvt_op_o,
  output Classif_e                 cvt_class_o,
  input  logic [31:0]              cvt_result_i,
  input  logic [2:0]               cvt_flag_i,
  output logic [2:0]               flag_sticky_o,
  input  logic                     flag_clr_i,
  output logic [31:0]              cvt_count_o,
  output logic                     busy_o
);

  localparam int unsigned ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [ID_W-1:0] RR_RESET = ID_W'(NUM_REQ - 1);

  // Exponents at or above 158 cannot be represented in 31 magnitude bits,
  // so they saturate here instead of reaching the converter's shifter.
  localparam logic [7:0] EXP_SAT = 8'd158;

  function automatic Classif_e classify(input logic [15:0] op);
    Classif_e cls;
    if (op[14:7] == 8'hFF && op[6:0] != 7'd0) begin
      cls = NaN;
    end else if (op[14:7] >= EXP_SAT) begin
      cls = op[15] ? Neg_Inf : Inf;
    end else if (op[14:7] == 8'd0) begin
      cls = Sub_Norm;
    end else begin
      cls = Norm;
    end
    return cls;
  endfunction

  // Pipeline state
  logic              iss_valid_q, iss_valid_d;
  logic [15:0]       iss_op_q, iss_op_d;
  logic [TAG_W-1:0]  iss_tag_q, iss_tag_d;
  logic [ID_W-1:0]   iss_id_q, iss_id_d;
  Classif_e          iss_class_q, iss_class_d;

  logic              res_valid_q, res_valid_d;
  logic [31:0]       res_result_q, res_result_d;
  logic [2:0]        res_flag_q, res_flag_d;
  logic [TAG_W-1:0]  res_tag_q, res_tag_d;
  logic [ID_W-1:0]   res_id_q, res_id_d;

  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [31:0]       count_q, count_d;
  logic [2:0]        sticky_q, sticky_d;

  // Control
  logic              res_drain;
  logic              res_load;
  logic              iss_accept;
  logic              accept;
  logic              grant_valid;
  logic [ID_W-1:0]   grant_id;
  logic [NUM_REQ-1:0] grant_oh;
  logic [15:0]       op_sel;
  logic [TAG_W-1:0]  tag_sel;
  int unsigned       idx;

  assign res_drain  = res_valid_q & rsp_ready_i[res_id_q];
  assign res_load   = ~res_valid_q | res_drain;
  // Issue can take a new entry if empty or if its current entry leaves now.
  assign iss_accept = ~iss_valid_q | res_load;

  // Round-robin: first valid requester strictly after the pointer, wrapping.
  always_comb begin
    grant_valid = 1'b0;
    grant_id    = '0;
    idx         = 0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      idx = 32'(rr_ptr_q) + k;
      if (idx >= NUM_REQ) begin
        idx = idx - NUM_REQ;
      end
      if (!grant_valid && req_valid_i[ID_W'(idx)]) begin
        grant_valid = 1'b1;
        grant_id    = ID_W'(idx);
      end
    end
  end

  always_comb begin
    grant_oh = '0;
    op_sel   = '0;
    tag_sel  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      grant_oh[i] = grant_valid && (grant_id == ID_W'(i));
      if (grant_id == ID_W'(i)) begin
        op_sel  = req_op_i[16*i +: 16];
        tag_sel = req_tag_i[TAG_W*i +: TAG_W];
      end
    end
  end

  // No transfers are offered while reset is held.
  assign req_ready_o = (iss_accept && !rst_i) ? grant_oh : '0;
  assign accept      = grant_valid & iss_accept & ~rst_i;

  always_comb begin
    iss_valid_d  = iss_valid_q;
    iss_op_d     = iss_op_q;
    iss_tag_d    = iss_tag_q;
    iss_id_d     = iss_id_q;
    iss_class_d  = iss_class_q;
    res_valid_d  = res_valid_q;
    res_result_d = res_result_q;
    res_flag_d   = res_flag_q;
    res_tag_d    = res_tag_q;
    res_id_d     = res_id_q;
    rr_ptr_d     = rr_ptr_q;
    count_d      = count_q;
    sticky_d     = sticky_q;

    if (iss_accept) begin
      iss_valid_d = accept;
      if (accept) begin
        iss_op_d    = op_sel;
        iss_tag_d   = tag_sel;
        iss_id_d    = grant_id;
        iss_class_d = classify(op_sel);
        rr_ptr_d    = grant_id;
      end
    end

    if (res_load) begin
      res_valid_d  = iss_valid_q;
      res_result_d = cvt_result_i;
      res_flag_d   = cvt_flag_i;
      res_tag_d    = iss_tag_q;
      res_id_d     = iss_id_q;
    end

    if (res_drain) begin
      count_d  = count_q + 32'd1;
      sticky_d = sticky_q | res_flag_q;
    end
    // Clear wins over a same-cycle delivery.
    if (flag_clr_i) begin
      sticky_d = 3'b000;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      iss_valid_q  <= 1'b0;
      iss_op_q     <= '0;
      iss_tag_q    <= '0;
      iss_id_q     <= '0;
      iss_class_q  <= Sub_Norm;
      res_valid_q  <= 1'b0;
      res_result_q <= '0;
      res_flag_q   <= '0;
      res_tag_q    <= '0;
      res_id_q     <= '0;
      rr_ptr_q     <= RR_RESET;
      count_q      <= '0;
      sticky_q     <= '0;
    end else begin
      iss_valid_q  <= iss_valid_d;
      iss_op_q     <= iss_op_d;
      iss_tag_q    <= iss_tag_d;
      iss_id_q     <= iss_id_d;
      iss_class_q  <= iss_class_d;
      res_valid_q  <= res_valid_d;
      res_result_q <= res_result_d;
      res_flag_q   <= res_flag_d;
      res_tag_q    <= res_tag_d;
      res_id_q     <= res_id_d;
      rr_ptr_q     <= rr_ptr_d;
      count_q      <= count_d;
      sticky_q     <= sticky_d;
    end
  end

  // Outputs are forced to zero when the owning stage is empty.
  assign cvt_op_o    = iss_valid_q ? iss_op_q : 16'd0;
  assign cvt_class_o = iss_valid_q ? iss_class_q : Sub_Norm;

  always_comb begin
    rsp_valid_o = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      rsp_valid_o[i] = res_valid_q && (res_id_q == ID_W'(i));
    end
  end

  assign rsp_result_o  = res_valid_q ? res_result_q : 32'd0;
  assign rsp_flag_o    = res_valid_q ? res_flag_q : 3'd0;
  assign rsp_tag_o     = res_valid_q ? res_tag_q : '0;
  assign flag_sticky_o = sticky_q;
  assign cvt_count_o   = count_q;
  assign busy_o        = iss_valid_q | res_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_fp2int_cvt_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_fp2int_cvt_sched                                        |
// | Description : Self-checking bench for fp2int_cvt_sched. A converter      |
// |               stand-in drives cvt_*_i from the DUT's cvt_*_o; expected   |
// |               responses come from a real-arithmetic reference model and  |
// |               an in-order scoreboard.                                    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_fp2int_cvt_sched;
  import fp2int_cvt_pkg::*;

  localparam int N  = 2;
  localparam int TW = 4;

  logic            clk_i = 1'b0;
  logic            rst_i = 1'b1;
  logic [N-1:0]    req_valid_i = '0;
  logic [N-1:0]    req_ready_o;
  logic [N*16-1:0] req_op_i = '0;
  logic [N*TW-1:0] req_tag_i = '0;
  logic [N-1:0]    rsp_valid_o;
  logic [N-1:0]    rsp_ready_i = '1;
  logic [31:0]     rsp_result_o;
  logic [2:0]      rsp_flag_o;
  logic [TW-1:0]   rsp_tag_o;
  logic [15:0]     cvt_op_o;
  Classif_e        cvt_class_o;
  logic [31:0]     cvt_result_i;
  logic [2:0]      cvt_flag_i;
  logic [2:0]      flag_sticky_o;
  logic            flag_clr_i = 1'b0;
  logic [31:0]     cvt_count_o;
  logic            busy_o;

  int tests = 0;
  int fails = 0;

  fp2int_cvt_sched #(.NUM_REQ(N), .TAG_W(TW)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_op_i(req_op_i), .req_tag_i(req_tag_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_result_o(rsp_result_o), .rsp_flag_o(rsp_flag_o), .rsp_tag_o(rsp_tag_o),
    .cvt_op_o(cvt_op_o), .cvt_class_o(cvt_class_o),
    .cvt_result_i(cvt_result_i), .cvt_flag_i(cvt_flag_i),
    .flag_sticky_o(flag_sticky_o), .flag_clr_i(flag_clr_i),
    .cvt_count_o(cvt_count_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  // Converter stand-in: acts on the class the DUT supplies.
  function automatic logic [34:0] conv_stub(input logic [15:0] op, input Classif_e cls);
    logic [38:0] wide;
    logic [31:0] mag;
    case (cls)
      NaN, Inf, Neg_Inf: return {32'hFFFF_FFFF, 3'b001};
      Norm: begin
        if (op[14:7] < 8'd127) return {32'd0, 3'b010};
        wide = {31'd0, 1'b1, op[6:0]} << (op[14:7] - 8'd127);
        mag  = wide[38:7];
        return {op[15], mag[30:0], 3'b000};
      end
      default: return {32'd0, (op[14:0] != 15'd0) ? 3'b010 : 3'b000};
    endcase
  endfunction

  assign {cvt_result_i, cvt_flag_i} = conv_stub(cvt_op_o, cvt_class_o);

  // Reference: value = (-1)^s * (1 + f/128) * 2^(e-127), truncated toward zero.
  function automatic logic [34:0] ref_cvt(input logic [15:0] op);
    int  e;
    int  f;
    real v;
    int  mag;
    e = int'(op[14:7]);
    f = int'(op[6:0]);
    if (e >= 158) return {32'hFFFF_FFFF, 3'b001};
    if (e == 0) return {32'd0, (f != 0) ? 3'b010 : 3'b000};
    v = (1.0 + f / 128.0) * (2.0 ** (e - 127));
    if (v < 1.0) return {32'd0, 3'b010};
    mag = $rtoi(v);
    return {op[15], mag[30:0], 3'b000};
  endfunction

  function automatic int rr_pick(input logic [N-1:0] v, input int p);
    for (int k = 1; k <= N; k++) begin
      if (v[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [15:0] rand_op();
    logic [7:0] e;
    case ($urandom_range(0, 5))
      0: e = 8'd0;
      1: e = 8'($urandom_range(1, 126));
      2, 3: e = 8'($urandom_range(127, 157));
      4: e = 8'($urandom_range(158, 254));
      default: e = 8'hFF;
    endcase
    return {1'($urandom), e, 7'($urandom)};
  endfunction

  // ---------------- scoreboard / monitor ----------------
  typedef struct {
    int            id;
    logic [TW-1:0] tag;
    logic [31:0]   res;
    logic [2:0]    flag;
  } exp_t;

  exp_t         exp_q[$];
  exp_t         mon_e;
  exp_t         new_e;
  int           mptr = N - 1;
  int           mon_did;
  int           mon_g;
  logic [N-1:0] exp_oh;
  logic [31:0]  mcount = '0;
  logic [2:0]   msticky = '0;
  logic [N-1:0] acc_seen = '0;

  always @(negedge clk_i) begin
    if (rst_i) begin
      exp_q.delete();
      mptr     = N - 1;
      mcount   = '0;
      msticky  = '0;
      acc_seen = '0;
    end else begin
      tests++;
      if (cvt_count_o !== mcount) begin
        fails++;
        $display("FAIL count: got %0d expected %0d", cvt_count_o, mcount);
      end
      tests++;
      if (flag_sticky_o !== msticky) begin
        fails++;
        $display("FAIL sticky: got %b expected %b", flag_sticky_o, msticky);
      end
      tests++;
      if (busy_o !== (exp_q.size() != 0)) begin
        fails++;
        $display("FAIL busy: got %b expected %b", busy_o, exp_q.size() != 0);
      end
      if (rsp_valid_o === '0) begin
        tests++;
        if (rsp_result_o !== 32'd0 || rsp_flag_o !== 3'd0 || rsp_tag_o !== '0) begin
          fails++;
          $display("FAIL idle_bus: got %h/%b/%h expected 0/0/0", rsp_result_o, rsp_flag_o, rsp_tag_o);
        end
      end else if (!$onehot(rsp_valid_o)) begin
        tests++;
        fails++;
        $display("FAIL rsp_onehot: got %b expected one-hot", rsp_valid_o);
      end else begin
        mon_did = 0;
        for (int i = 0; i < N; i++) if (rsp_valid_o[i]) mon_did = i;
        if (rsp_ready_i[mon_did]) begin
          tests++;
          if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL rsp_extra: got response id %0d expected none", mon_did);
          end else begin
            mon_e = exp_q.pop_front();
            if (mon_did != mon_e.id || rsp_result_o !== mon_e.res ||
                rsp_flag_o !== mon_e.flag || rsp_tag_o !== mon_e.tag) begin
              fails++;
              $display("FAIL rsp_data: got id%0d %h/%b tag %h expected id%0d %h/%b tag %h",
                       mon_did, rsp_result_o, rsp_flag_o, rsp_tag_o,
                       mon_e.id, mon_e.res, mon_e.flag, mon_e.tag);
            end
            mcount  = mcount + 32'd1;
            msticky = msticky | mon_e.flag;
          end
        end
      end
      if (flag_clr_i) msticky = '0;

      acc_seen = req_valid_i & req_ready_o;
      if (req_ready_o !== '0) begin
        mon_g  = rr_pick(req_valid_i, mptr);
        exp_oh = '0;
        if (mon_g >= 0) exp_oh[mon_g] = 1'b1;
        tests++;
        if (req_ready_o !== exp_oh) begin
          fails++;
          $display("FAIL grant: got %b expected %b", req_ready_o, exp_oh);
        end
      end
      for (int i = 0; i < N; i++) begin
        if (acc_seen[i]) begin
          new_e.id  = i;
          new_e.tag = req_tag_i[TW*i +: TW];
          {new_e.res, new_e.flag} = ref_cvt(req_op_i[16*i +: 16]);
          exp_q.push_back(new_e);
          mptr = i;
        end
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic reset_dut();
    @(posedge clk_i); #1;
    rst_i       = 1'b1;
    req_valid_i = '0;
    rsp_ready_i = '1;
    flag_clr_i  = 1'b0;
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;
  endtask

  task automatic drive(input int id, input logic [15:0] op, input logic [TW-1:0] tag);
    req_op_i[16*id +: 16]  = op;
    req_tag_i[TW*id +: TW] = tag;
    req_valid_i[id]        = 1'b1;
  endtask

  // Waits (bounded) for requester id to be accepted, then drops its valid.
  task automatic wait_acc(input int id, input string nm);
    for (int c = 0; c < 30; c++) begin
      @(negedge clk_i);
      if (req_valid_i[id] && req_ready_o[id]) begin
        @(posedge clk_i); #1 req_valid_i[id] = 1'b0;
        return;
      end
    end
    tests++;
    fails++;
    $display("FAIL %s: got no accept for req%0d expected accept within 30 cycles", nm, id);
    req_valid_i[id] = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    for (int c = 0; c < 40; c++) begin
      @(negedge clk_i);
      if (!busy_o) return;
    end
    tests++;
    fails++;
    $display("FAIL %s: got busy=1 expected idle within 40 cycles", nm);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset_dut();
    @(negedge clk_i);
    tests++;
    if ({rsp_valid_o, req_ready_o, rsp_result_o, rsp_flag_o, rsp_tag_o} !== '0) begin
      fails++;
      $display("FAIL reset_rsp: got v%b r%b %h/%b/%h expected all 0",
               rsp_valid_o, req_ready_o, rsp_result_o, rsp_flag_o, rsp_tag_o);
    end
    tests++;
    if (cvt_op_o !== 16'd0 || cvt_class_o !== Sub_Norm) begin
      fails++;
      $display("FAIL reset_cvt: got %h/%0d expected 0000/Sub_Norm", cvt_op_o, cvt_class_o);
    end
    tests++;
    if (flag_sticky_o !== 3'd0 || cvt_count_o !== 32'd0 || busy_o !== 1'b0) begin
      fails++;
      $display("FAIL reset_ctr: got %b/%0d/%b expected 000/0/0", flag_sticky_o, cvt_count_o, busy_o);
    end
  endtask

  localparam int          D_N = 10;
  localparam int          D_ID   [D_N] = '{0, 1, 1, 0, 0, 1, 0, 1, 0, 1};
  localparam logic [15:0] D_OP   [D_N] = '{16'h3F80, 16'hC120, 16'h4120, 16'h7F80, 16'h4F00,
                                           16'h0001, 16'hFF80, 16'h7FC1, 16'hCE80, 16'h8000};
  localparam logic [31:0] D_RES  [D_N] = '{32'h0000_0001, 32'h8000_000A, 32'h0000_000A, 32'hFFFF_FFFF,
                                           32'hFFFF_FFFF, 32'h0000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                                           32'hC000_0000, 32'h0000_0000};
  localparam logic [2:0]  D_FLAG [D_N] = '{3'b000, 3'b000, 3'b000, 3'b001, 3'b001,
                                           3'b010, 3'b001, 3'b001, 3'b000, 3'b000};
  localparam Classif_e    D_CLS  [D_N] = '{Norm, Norm, Norm, Inf, Inf,
                                           Sub_Norm, Neg_Inf, NaN, Norm, Sub_Norm};

  task automatic test_directed();
    logic [N-1:0]  oh;
    logic [TW-1:0] tag;
    for (int t = 0; t < D_N; t++) begin
      oh          = '0;
      oh[D_ID[t]] = 1'b1;
      tag         = TW'(t + 5);
      @(posedge clk_i); #1;
      rsp_ready_i = '1;
      drive(D_ID[t], D_OP[t], tag);
      @(negedge clk_i);
      tests++;
      if (req_ready_o !== oh) begin
        fails++;
        $display("FAIL dir%0d_accept: got %b expected %b", t, req_ready_o, oh);
      end
      @(posedge clk_i); #1 req_valid_i = '0;
      @(negedge clk_i);
      tests++;
      if (cvt_op_o !== D_OP[t] || cvt_class_o !== D_CLS[t]) begin
        fails++;
        $display("FAIL dir%0d_class: got %h/%0d expected %h/%0d", t, cvt_op_o, cvt_class_o, D_OP[t], D_CLS[t]);
      end
      @(posedge clk_i); #1;
      tests++;
      if (rsp_valid_o !== oh || rsp_result_o !== D_RES[t] || rsp_flag_o !== D_FLAG[t] || rsp_tag_o !== tag) begin
        fails++;
        $display("FAIL dir%0d_rsp: got v%b %h/%b tag %h expected v%b %h/%b tag %h", t,
                 rsp_valid_o, rsp_result_o, rsp_flag_o, rsp_tag_o, oh, D_RES[t], D_FLAG[t], tag);
      end
    end
    wait_idle("dir_drain");
    tests++;
    if (flag_sticky_o !== 3'b011) begin
      fails++;
      $display("FAIL sticky_accum: got %b expected 011", flag_sticky_o);
    end
    @(posedge clk_i); #1 flag_clr_i = 1'b1;
    @(posedge clk_i); #1 flag_clr_i = 1'b0;
    @(negedge clk_i);
    tests++;
    if (flag_sticky_o !== 3'b000) begin
      fails++;
      $display("FAIL sticky_clr: got %b expected 000", flag_sticky_o);
    end
  endtask

  task automatic test_back_to_back();
    int           cnt[N];
    int           acc_n;
    logic [N-1:0] acc;
    logic [N-1:0] oh;
    reset_dut();
    acc_n = 0;
    for (int i = 0; i < N; i++) begin
      cnt[i] = 0;
      drive(i, rand_op(), TW'(0));
    end
    for (int c = 0; c < 40 && acc_n < 16; c++) begin
      @(negedge clk_i);
      acc         = req_valid_i & req_ready_o;
      oh          = '0;
      oh[acc_n % 2] = 1'b1;
      tests++;
      if (acc !== oh) begin
        fails++;
        $display("FAIL b2b_grant%0d: got %b expected %b", acc_n, acc, oh);
      end
      @(posedge clk_i); #1;
      for (int i = 0; i < N; i++) begin
        if (acc[i]) begin
          acc_n++;
          cnt[i]++;
          if (cnt[i] == 8) req_valid_i[i] = 1'b0;
          else drive(i, rand_op(), TW'(cnt[i]));
        end
      end
    end
    req_valid_i = '0;
    wait_idle("b2b_drain");
    tests++;
    if (cvt_count_o !== 32'd16) begin
      fails++;
      $display("FAIL b2b_count: got %0d expected 16", cvt_count_o);
    end
  endtask

  task automatic test_stall();
    logic [15:0]   op_b;
    logic [N-1:0]  rv;
    logic [TW-1:0] tg;
    logic [31:0]   c0;
    @(posedge clk_i); #1;
    c0          = cvt_count_o;
    rsp_ready_i = '0;
    drive(0, 16'h4040, TW'(1));
    wait_acc(0, "stall_a");
    op_b = 16'h40A0;
    drive(1, op_b, TW'(2));
    wait_acc(1, "stall_b");
    drive(0, 16'hC0E0, TW'(3));
    @(negedge clk_i);
    rv = rsp_valid_o;
    tg = rsp_tag_o;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk_i);
      tests++;
      if (req_ready_o !== '0 || rsp_valid_o !== rv || rv !== 2'b01 || rsp_tag_o !== tg ||
          cvt_op_o !== op_b || busy_o !== 1'b1) begin
        fails++;
        $display("FAIL stall_hold%0d: got rdy%b v%b tag%h op%h expected rdy00 v01 tag%h op%h",
                 c, req_ready_o, rsp_valid_o, rsp_tag_o, cvt_op_o, tg, op_b);
      end
    end
    @(posedge clk_i); #1 rsp_ready_i = '1;
    wait_acc(0, "stall_c");
    wait_idle("stall_drain");
    tests++;
    if (cvt_count_o !== c0 + 32'd3) begin
      fails++;
      $display("FAIL stall_count: got %0d expected %0d", cvt_count_o, c0 + 32'd3);
    end
  endtask

  task automatic test_reset_midflight();
    logic [31:0] c0;
    reset_dut();
    rsp_ready_i = '0;
    drive(0, 16'h3F80, TW'(4));
    wait_acc(0, "rmf_a");
    drive(1, 16'h4000, TW'(5));
    wait_acc(1, "rmf_b");
    drive(0, 16'h4100, TW'(6));
    drive(1, 16'h4180, TW'(7));
    @(negedge clk_i);
    c0 = cvt_count_o;
    tests++;
    if (busy_o !== 1'b1 || rsp_valid_o === '0) begin
      fails++;
      $display("FAIL rmf_full: got busy%b v%b expected busy1 v!=0", busy_o, rsp_valid_o);
    end
    @(posedge clk_i); #1 rst_i = 1'b1;
    @(posedge clk_i); #1 rst_i = 1'b0;
    @(negedge clk_i);
    tests++;
    if (rsp_valid_o !== '0 || busy_o !== 1'b0 || cvt_count_o !== c0) begin
      fails++;
      $display("FAIL rmf_drop: got v%b busy%b count%0d expected v00 busy0 count%0d",
               rsp_valid_o, busy_o, cvt_count_o, c0);
    end
    tests++;
    if (req_ready_o !== 2'b01) begin
      fails++;
      $display("FAIL rmf_grant: got %b expected 01", req_ready_o);
    end
    rsp_ready_i = '1;
    wait_acc(0, "rmf_c");
    wait_acc(1, "rmf_d");
    wait_idle("rmf_drain");
  endtask

  task automatic test_random();
    int rem[N];
    for (int i = 0; i < N; i++) rem[i] = 60;
    for (int c = 0; c < 2000; c++) begin
      @(posedge clk_i); #1;
      for (int i = 0; i < N; i++) begin
        if (req_valid_i[i] && acc_seen[i]) req_valid_i[i] = 1'b0;
        if (!req_valid_i[i] && rem[i] > 0 && $urandom_range(0, 3) != 0) begin
          drive(i, rand_op(), TW'($urandom));
          rem[i]--;
        end
      end
      for (int i = 0; i < N; i++) rsp_ready_i[i] = ($urandom_range(0, 3) != 0);
      flag_clr_i = ($urandom_range(0, 15) == 0);
      if (rem[0] == 0 && rem[1] == 0 && req_valid_i == '0) break;
    end
    flag_clr_i  = 1'b0;
    rsp_ready_i = '1;
    req_valid_i = '0;
    wait_idle("rand_drain");
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL rand_lost: got %0d undelivered expected 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_stall();
    test_reset_midflight();
    test_random();
    @(posedge clk_i);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no completion expected finish within 1ms");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
